jam_detect_ctrl: RTL



---
 rtl/jam_detect_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/jam_detect_ctrl.sv
// Per-lane queue counting with hysteresis jam flags, plus the enable/start/rotation
// strobe sequencer for the jam operation unit. Optional jam_event_cnt via JAM_STATS_EN.
module jam_detect_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned JAM_TH   = 20,
  parameter int unsigned CLEAR_TH = 10,
  parameter int unsigned SLOT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        car_in_0,
  input  logic        car_in_1,
  input  logic        car_in_2,
  input  logic        car_in_3,
  input  logic        car_out_0,
  input  logic        car_out_1,
  input  logic        car_out_2,
  input  logic        car_out_3,
  output logic        traffic_jam_0,
  output logic        traffic_jam_1,
  output logic        traffic_jam_2,
  output logic        traffic_jam_3,
  output logic        jam_op_en,
  output logic        jam_start,
`ifdef JAM_STATS_EN
  output logic        jam_rotation,
  output logic [15:0] jam_event_cnt
`else
  output logic        jam_rotation
`endif
);

  localparam int unsigned N_LANE = 4;
  localparam int unsigned TMR_W  = $clog2(SLOT_CYC);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] JAM_LVL    = CNT_W'(JAM_TH);
  localparam logic [CNT_W-1:0] CLEAR_LVL  = CNT_W'(CLEAR_TH);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SLOT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [N_LANE-1:0] w_in;
  logic [N_LANE-1:0] w_out;
  logic [CNT_W-1:0]  r_cnt [N_LANE];
  logic [N_LANE-1:0] r_flag;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  r_tmr;
  logic [TMR_W-1:0]  w_tmr_nxt;
  logic              r_op_en;
  logic              r_start;
  logic              r_rot;
  logic              w_op_en_nxt;
  logic              w_start_nxt;
  logic              w_rot_nxt;

  assign w_in  = {car_in_3, car_in_2, car_in_1, car_in_0};
  assign w_out = {car_out_3, car_out_2, car_out_1, car_out_0};

  // Saturating queue counters; flags compare the registered count, so they trail by a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LANE; i++) r_cnt[i] <= '0;
      r_flag <= '0;
    end else begin
      for (int i = 0; i < N_LANE; i++) begin
        if (w_in[i] && !w_out[i] && (r_cnt[i] != CNT_MAX))
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_out[i] && !w_in[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - 1'b1;

        if (r_cnt[i] >= JAM_LVL)
          r_flag[i] <= 1'b1;
        else if (r_cnt[i] <= CLEAR_LVL)
          r_flag[i] <= 1'b0;
      end
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_op_en <= 1'b0;
      r_start <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_op_en <= w_op_en_nxt;
      r_start <= w_start_nxt;
      r_rot   <= w_rot_nxt;
    end
  end

  // Timer loads on START entry so the first rotation lands SLOT_CYC cycles after jam_start
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_op_en_nxt = 1'b0;
    w_start_nxt = 1'b0;
    w_rot_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_flag) begin
          w_state_nxt = ST_START;
          w_tmr_nxt   = TMR_RELOAD;
          w_op_en_nxt = 1'b1;
          w_start_nxt = 1'b1;
        end
      end
      ST_START: begin
        w_state_nxt = ST_HOLD;
        w_tmr_nxt   = r_tmr - 1'b1;
        w_op_en_nxt = 1'b1;
      end
      ST_HOLD: begin
        if (~|r_flag) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else if (r_tmr == '0) begin
          w_tmr_nxt   = TMR_RELOAD;
          w_op_en_nxt = 1'b1;
          w_rot_nxt   = 1'b1;
        end else begin
          w_tmr_nxt   = r_tmr - 1'b1;
          w_op_en_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

`ifdef JAM_STATS_EN
  logic [15:0] r_evt_cnt;
  logic        w_evt_inc;

  assign w_evt_inc = (r_state == ST_IDLE) && (w_state_nxt == ST_START);

  always_ff @(posedge clk) begin
    if (rst)
      r_evt_cnt <= '0;
    else if (w_evt_inc && (r_evt_cnt != 16'hFFFF))
      r_evt_cnt <= r_evt_cnt + 16'd1;
  end

  assign jam_event_cnt = r_evt_cnt;
`endif

  assign traffic_jam_0 = r_flag[0];
  assign traffic_jam_1 = r_flag[1];
  assign traffic_jam_2 = r_flag[2];
  assign traffic_jam_3 = r_flag[3];
  assign jam_op_en     = r_op_en;
  assign jam_start     = r_start;
  assign jam_rotation  = r_rot;

endmodule
